// File: rtl/ethernet_type_pkg.sv
// Shared IEEE EtherType code points used across the FrameLink
// generator and checker path.
package ethernet_type_pkg;

   localparam logic [15:0] ETH_TYPE_MIN     = 16'h0600;
   localparam logic [15:0] ETH_TYPE_IPV4    = 16'h0800;
   localparam logic [15:0] ETH_TYPE_ARP     = 16'h0806;
   localparam logic [15:0] ETH_TYPE_RARP    = 16'h8035;
   localparam logic [15:0] ETH_TYPE_IPV6    = 16'h86DD;
   localparam logic [15:0] ETH_TYPE_MPLS_UC = 16'h8847;
   localparam logic [15:0] ETH_TYPE_MPLS_MC = 16'h8848;
   localparam logic [15:0] ETH_TYPE_VLAN    = 16'h8100;
   localparam logic [15:0] ETH_TYPE_QINQ    = 16'h88A8;
   localparam logic [15:0] ETH_TYPE_Q9100   = 16'h9100;
   localparam logic [15:0] ETH_TYPE_Q9200   = 16'h9200;
   localparam logic [15:0] ETH_TYPE_Q9300   = 16'h9300;

endpackage

// File: rtl/fl_ethtype_classifier_pkg.sv
// Types and constants for the EtherType classifier.
// Stats build selected by FL_ETHTYPE_CLASSIFIER_STATS_EN.
package fl_ethtype_classifier_pkg;

   import ethernet_type_pkg::*;

   typedef enum logic [2:0] {
      CLS_RUNT     = 3'd0,
      CLS_IPV4     = 3'd1,
      CLS_IPV6     = 3'd2,
      CLS_MPLS     = 3'd3,
      CLS_ARP      = 3'd4,
      CLS_RARP     = 3'd5,
      CLS_OTHER    = 3'd6,
      CLS_VLAN_OVF = 3'd7
   } eth_class_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MAC,
      ST_TYPE,
      ST_TCI,
      ST_SKIP
   } walk_state_e;

   typedef struct packed {
      eth_class_e  cls;
      logic [2:0]  vlan_cnt;
      logic [7:0]  l3_off;
   } res_t;

   localparam int unsigned ETH_HDR_WORDS  = 6;
   localparam int unsigned L3_BASE_OFFSET = 14;
   localparam int unsigned TPID_NUM       = 5;

   localparam logic [15:0] TPID_LIST [TPID_NUM] = '{
      ETH_TYPE_VLAN,
      ETH_TYPE_QINQ,
      ETH_TYPE_Q9100,
      ETH_TYPE_Q9200,
      ETH_TYPE_Q9300
   };

`ifdef FL_ETHTYPE_CLASSIFIER_STATS_EN
   localparam bit STATS_EN = 1'b1;
`else
   localparam bit STATS_EN = 1'b0;
`endif

   function automatic logic is_tpid(input logic [15:0] w);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < TPID_NUM; i++)
         hit = hit | (w == TPID_LIST[i]);
      return hit;
   endfunction

   function automatic logic [7:0] l3_offset(input logic [2:0] v);
      return 8'(L3_BASE_OFFSET) + {3'b000, v, 2'b00};
   endfunction

endpackage

// File: rtl/fl_ethtype_classifier_if.sv
// FrameLink receive stream plus classification result channel.
// slave = classifier side, master = source/consumer side.
interface fl_ethtype_classifier_if;

   logic [15:0] RX_DATA;
   logic        RX_SOF_N;
   logic        RX_EOF_N;
   logic        RX_SRC_RDY_N;
   logic        RX_DST_RDY_N;
   logic        RES_VLD;
   logic        RES_RDY;
   logic [2:0]  RES_CLASS;
   logic [2:0]  RES_VLAN_CNT;
   logic [7:0]  RES_L3_OFFSET;

   modport master (
      output RX_DATA, RX_SOF_N, RX_EOF_N,
      output RX_SRC_RDY_N, RES_RDY,
      input  RX_DST_RDY_N, RES_VLD,
      input  RES_CLASS, RES_VLAN_CNT,
      input  RES_L3_OFFSET
   );

   modport slave (
      input  RX_DATA, RX_SOF_N, RX_EOF_N,
      input  RX_SRC_RDY_N, RES_RDY,
      output RX_DST_RDY_N, RES_VLD,
      output RES_CLASS, RES_VLAN_CNT,
      output RES_L3_OFFSET
   );

endinterface

// File: rtl/fl_ethtype_classifier_decode.sv
// Combinational EtherType word decoder: TPID flag and class.
module fl_ethtype_decode
   import fl_ethtype_classifier_pkg::*;
   import ethernet_type_pkg::*;
(
   input  logic [15:0] word_i,
   output logic        tpid_o,
   output eth_class_e  class_o
);

   always_comb begin
      tpid_o  = is_tpid(word_i);
      class_o = CLS_OTHER;
      unique case (1'b1)
         (word_i == ETH_TYPE_IPV4):    class_o = CLS_IPV4;
         (word_i == ETH_TYPE_IPV6):    class_o = CLS_IPV6;
         (word_i == ETH_TYPE_MPLS_UC),
         (word_i == ETH_TYPE_MPLS_MC): class_o = CLS_MPLS;
         (word_i == ETH_TYPE_ARP):     class_o = CLS_ARP;
         (word_i == ETH_TYPE_RARP):    class_o = CLS_RARP;
         default:                      class_o = CLS_OTHER;
      endcase
   end

endmodule

// File: rtl/fl_ethtype_classifier.sv
// Ethernet header walker: skips VLAN tags, classifies EtherType.
// FL_ETHTYPE_CLASSIFIER_STATS_EN adds per-class frame counters.
module fl_ethtype_classifier
   import fl_ethtype_classifier_pkg::*;
#(
   parameter int unsigned MAX_VLAN = 2
) (
   input  logic        CLK,
   input  logic        RESET_N,
`ifdef FL_ETHTYPE_CLASSIFIER_STATS_EN
   input  logic [2:0]  STAT_SEL,
   input  logic        STAT_CLR,
   output logic [31:0] STAT_CNT,
`endif
   fl_ethtype_classifier_if.slave fl
);

   localparam logic [2:0] MAX_V    = 3'(MAX_VLAN);
   localparam logic [2:0] MAC_LAST = 3'(ETH_HDR_WORDS - 1);

   walk_state_e state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  vlan_q, vlan_d;
   res_t        res_q, res_d;
   logic        vld_q, vld_d;

   logic        stall, acc, sof, eof;
   logic        emit;
   eth_class_e  emit_cls;
   logic [2:0]  emit_vlan;
   logic        dec_tpid;
   eth_class_e  dec_cls;

   fl_ethtype_decode u_dec (
      .word_i  (fl.RX_DATA),
      .tpid_o  (dec_tpid),
      .class_o (dec_cls)
   );

   // Combinational from RES_RDY: only header states hold off the source
   assign stall = vld_q & ~fl.RES_RDY &
                  (state_q inside {ST_MAC, ST_TYPE, ST_TCI});
   assign fl.RX_DST_RDY_N = stall;
   assign acc = ~fl.RX_SRC_RDY_N & ~stall;
   assign sof = ~fl.RX_SOF_N;
   assign eof = ~fl.RX_EOF_N;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      vlan_d    = vlan_q;
      emit      = 1'b0;
      emit_cls  = CLS_RUNT;
      emit_vlan = vlan_q;
      if (acc) begin
         if (sof) begin
            vlan_d    = '0;
            emit_vlan = '0;
            if (eof) begin
               emit    = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_MAC;
               cnt_d   = 3'd1;
            end
         end else begin
            unique case (state_q)
               ST_IDLE: state_d = ST_IDLE;
               ST_MAC: begin
                  if (eof) begin
                     emit    = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     if (cnt_q != 3'd7)
                        cnt_d = cnt_q + 3'd1;
                     if (cnt_q == MAC_LAST)
                        state_d = ST_TYPE;
                  end
               end
               ST_TYPE: begin
                  if (dec_tpid && (vlan_q < MAX_V)) begin
                     vlan_d  = vlan_q + 3'd1;
                     emit    = eof;
                     state_d = eof ? ST_IDLE : ST_TCI;
                  end else begin
                     emit     = 1'b1;
                     emit_cls = dec_tpid ? CLS_VLAN_OVF
                                         : dec_cls;
                     state_d  = eof ? ST_IDLE : ST_SKIP;
                  end
               end
               ST_TCI: begin
                  emit    = eof;
                  state_d = eof ? ST_IDLE : ST_TYPE;
               end
               ST_SKIP: if (eof) state_d = ST_IDLE;
               default: state_d = ST_IDLE;
            endcase
         end
         if (state_d == ST_IDLE)
            cnt_d = '0;
      end
   end

   // A fresh record overrides a same-cycle consume
   always_comb begin
      vld_d = vld_q;
      res_d = res_q;
      if (vld_q && fl.RES_RDY)
         vld_d = 1'b0;
      if (emit) begin
         vld_d          = 1'b1;
         res_d.cls      = emit_cls;
         res_d.vlan_cnt = emit_vlan;
         res_d.l3_off   = l3_offset(emit_vlan);
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         vlan_q  <= '0;
         vld_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vlan_q  <= vlan_d;
         vld_q   <= vld_d;
         res_q   <= res_d;
      end
   end

   assign fl.RES_VLD       = vld_q;
   assign fl.RES_CLASS     = res_q.cls;
   assign fl.RES_VLAN_CNT  = res_q.vlan_cnt;
   assign fl.RES_L3_OFFSET = res_q.l3_off;

`ifdef FL_ETHTYPE_CLASSIFIER_STATS_EN
   logic [31:0] stat_q [8];
   logic [31:0] stat_cnt_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < 8; i++)
            stat_q[i] <= '0;
         stat_cnt_q <= '0;
      end else begin
         if (STAT_CLR) begin
            for (int i = 0; i < 8; i++)
               stat_q[i] <= '0;
         end else if (emit && (stat_q[emit_cls] != '1)) begin
            stat_q[emit_cls] <= stat_q[emit_cls] + 32'd1;
         end
         stat_cnt_q <= stat_q[STAT_SEL];
      end
   end

   assign STAT_CNT = stat_cnt_q;
`endif

endmodule

// File: doc/fl_ethtype_classifier.md
# fl_ethtype_classifier

Streaming Ethernet header walker for the 16-bit FrameLink packet-generator and checker path. It parses each frame's MAC header, skips up to MAX_VLAN stacked VLAN/QinQ tags, and classifies the final EtherType. It delivers one result record per frame over a valid/ready handshake. It sits as a flow-controlled tap in front of the per-protocol generator and checker schedulers, which use the result to pick the next stage.

## Interface
- MAX_VLAN, 2, maximum accepted tag depth, legal range 0..6
- CLK  in  1  clock
- RESET_N  in  1  asynchronous, active-low reset
- RX_DATA  in  16  frame word, big-endian byte order (byte 0 in [15:8])
- RX_SOF_N  in  1  start of frame, active-low
- RX_EOF_N  in  1  end of frame, active-low
- RX_SRC_RDY_N  in  1  source ready, active-low
- RX_DST_RDY_N  out  1  sink ready, active-low
- RES_VLD  out  1  result record valid
- RES_RDY  in  1  result consumed
- RES_CLASS  out  3  0 RUNT, 1 IPV4, 2 IPV6, 3 MPLS (uni or multi), 4 ARP, 5 RARP, 6 OTHER, 7 VLAN_OVF
- RES_VLAN_CNT  out  3  number of tags skipped
- RES_L3_OFFSET  out  8  byte offset of the L3 header, 14 + 4*RES_VLAN_CNT

## Operation
- A word is accepted when RX_SRC_RDY_N=0 and RX_DST_RDY_N=0.
- States are IDLE, MAC, TYPE, TCI and SKIP.
- IDLE: non-SOF words are accepted and dropped. An accepted SOF word goes to MAC with the word counter set to 1.
- MAC: counts words 1..5. On the 6th MAC word the FSM goes to TYPE.
- TYPE: the accepted word is the EtherType.
  - If it is a TPID (0x8100, 0x88A8, 0x9100, 0x9200, 0x9300):
    - vlan_cnt < MAX_VLAN: increment vlan_cnt and go to TCI.
    - otherwise: emit class 7 and go to SKIP.
  - Otherwise: emit the class per the encoding; any unlisted value, including length fields < 0x0600, is OTHER. Then go to SKIP.
- TCI: the accepted word is skipped, then go to TYPE.
- SKIP: accept words until EOF, then go to IDLE.
- EOF on the classifying word: emit the result and go directly to IDLE.
- EOF in MAC or TCI: emit RUNT with the current vlan_cnt, then go to IDLE.
- SOF in any state other than IDLE aborts the current frame with no result and restarts at MAC with counter 1. A word carrying both SOF and EOF emits RUNT.
- Result register holds one entry.
  - Set on emit; cleared when RES_VLD and RES_RDY are both high.
  - Emit and clear in the same cycle: the new record wins.
- Backpressure: RX_DST_RDY_N = 1 when RES_VLD=1 and RES_RDY=0 and the state is MAC, TYPE or TCI. Otherwise RX_DST_RDY_N = 0. This is a combinational path from RES_RDY and is documented as such.

## Timing
- Reset values: state IDLE, RES_VLD=0, RES_CLASS=0, RES_VLAN_CNT=0, RES_L3_OFFSET=0, RX_DST_RDY_N=0, all counters 0.
- Latency: RES_VLD rises on the clock edge that accepts the classifying word, so it is visible in the next cycle.
- Zero-bubble operation: back-to-back frames with RES_RDY held at 1 are never stalled.
- Minimum classifiable frame is 7 words; each tag adds 2 words.
- Reset asserted mid-frame: all state clears immediately. The remainder of that frame is consumed in IDLE and dropped.
- The word counter is 3 bits and saturates; it never wraps inside a frame.

## Configuration
- FL_ETHTYPE_CLASSIFIER_STATS_EN compiles in per-class 32-bit frame counters and these ports:
  - STAT_SEL in 3: selects the class counter.
  - STAT_CNT out 32: registered value of the selected counter, 1-cycle latency.
  - STAT_CLR in 1: synchronous clear of all counters.
- Counter behaviour:
  - Each counter increments on emit and saturates at 0xFFFFFFFF.
  - STAT_CLR in the same cycle as an emit: clear wins.
  - Counters reset to 0.
- Without the macro, the counters and their ports do not exist, and behaviour is otherwise identical.

## Structure
- Shared package fl_ethtype_classifier_pkg:
  - class enum (3 bits)
  - constants ETH_HDR_WORDS=6 and L3_BASE_OFFSET=14
  - TPID list
- EtherType values are imported from ethernet_type_pkg; they are not redefined.
- Sub-module fl_ethtype_decode: combinational word → {is_tpid, class}. All sequential logic stays in the top module.

## Test plan
- Untagged frame, EtherType 0x0800, 32 words, RES_RDY=1 → one result, class 1, vlan 0, offset 14; RES_VLD asserted the cycle after word 6; no stall.
- Tag 0x8100 then 0x86DD → class 2, vlan 1, offset 18.
- MAX_VLAN=2, tags 0x88A8, 0x8100, then 0x0806 → class 4, vlan 2, offset 22. Same frame with a third tag 0x9100 → class 7, vlan 2.
- 5-word frame with EOF on word 4; then a SOF injected at word 3 of the next frame → exactly one RUNT for the first frame; the second frame restarts and classifies normally.
- RES_RDY=0 with two consecutive IPv4 frames → the second frame stalls at word 1 (RX_DST_RDY_N=1) until RES_RDY pulses; the results are delivered in order with no loss.
- RESET_N pulsed low during TCI; the frame tail then arrives, followed by a clean 0x8847 frame → no result from the aborted frame; class 3 for the clean frame; with STATS_EN, STAT_CNT for class 3 reads 1.
